local_flit_receiver: RTL and testbench

// - Neuron-side receive end of the router local output port.
// - Accepts 4-bit flits from the router local output, qualified by the router write request.
// - Reassembles each group of 8 flits into one 32-bit packet and buffers packets in a small FIFO.
// - Presents packets to the neuron core with valid/ready; drives the router's local destination-full input.

---
 rtl/noc_pkg.sv | 8 +
 rtl/pkt_fifo.sv | 56 +++++
 rtl/local_flit_receiver.sv | 103 ++++++++++
 tb/tb_local_flit_receiver.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared packet/flit geometry and receive-state encoding for the local flit receiver.
package noc_pkg;
    localparam int PACKET_SIZE   = 32;
    localparam int FLIT_SIZE     = 4;
    localparam int FLITS_PER_PKT = PACKET_SIZE / FLIT_SIZE;

    typedef enum logic {RX_IDLE, RX_ASSEMBLE} rx_state_t;
endpackage

// File: rtl/pkt_fifo.sv
// Show-ahead packet FIFO with a registered head: a push into an empty FIFO
// becomes visible on head_valid one cycle later. A push into a full FIFO with no pop is dropped.
module pkt_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             ready,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [CW-1:0]    next_count,
    output logic             dropped
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr, rd_next;
    logic [CW-1:0]    count, after_pop;
    logic             pop, do_push;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        pop        = head_valid && ready;
        do_push    = push && ((count != CW'(DEPTH)) || pop);
        dropped    = push && !do_push;
        rd_next    = rd_ptr + PW'(pop);
        after_pop  = count - CW'(pop);
        next_count = after_pop + CW'(do_push);
    end

    // NOTE: storage is left unreset; count and head_valid alone decide what is meaningful.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // NOTE: registered state uses non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else begin
            wr_ptr     <= wr_ptr + PW'(do_push);
            rd_ptr     <= rd_next;
            count      <= next_count;
            // Head reloads from storage only; this edge's push shows up next cycle.
            head_valid <= (after_pop != '0);
            if (after_pop != '0) head_data <= mem[rd_next];
        end
    end
endmodule

// File: rtl/local_flit_receiver.sv
// Reassembles 8 LS-nibble-first flits into 32-bit packets and queues them for the neuron core.
// Optional idle-timeout discard of partial packets is built when RX_TIMEOUT_EN is defined.
module local_flit_receiver
    import noc_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
`ifdef RX_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [FLIT_SIZE-1:0]   flit_in,
    input  logic                   write_req,
    output logic                   neuron_full,
    output logic [PACKET_SIZE-1:0] pkt_data,
    output logic                   pkt_valid,
    input  logic                   pkt_ready,
    output logic                   overflow_err,
    output logic                   timeout_err
);
    localparam int FCW  = $clog2(FLITS_PER_PKT);
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);
    localparam int SRW  = PACKET_SIZE - FLIT_SIZE;

    rx_state_t              state;
    logic [FCW-1:0]         flit_cnt;
    logic [SRW-1:0]         shift_reg;
    logic [PACKET_SIZE-1:0] assembled;
    logic                   last_flit;
    logic                   timeout_hit;
    logic [CNTW-1:0]        next_count;
    logic                   dropped;

    // The shift register keeps the previous seven flits; the live flit completes the word.
    assign assembled = {flit_in, shift_reg};
    assign last_flit = (state == RX_ASSEMBLE) && write_req && (flit_cnt == FCW'(FLITS_PER_PKT - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= RX_IDLE;
            flit_cnt  <= '0;
            shift_reg <= '0;
        end else if (write_req) begin
            shift_reg <= assembled[PACKET_SIZE-1:FLIT_SIZE];
            if (last_flit) begin
                state    <= RX_IDLE;
                flit_cnt <= '0;
            end else begin
                state    <= RX_ASSEMBLE;
                flit_cnt <= flit_cnt + 1'b1;
            end
        end else if (timeout_hit) begin
            state     <= RX_IDLE;
            flit_cnt  <= '0;
            shift_reg <= '0;
        end
    end

`ifdef RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt;

    assign timeout_hit = (state == RX_ASSEMBLE) && !write_req && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            idle_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if ((state != RX_ASSEMBLE) || write_req || timeout_hit) idle_cnt <= '0;
            else                                                   idle_cnt <= idle_cnt + 1'b1;
            if (timeout_hit) timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    pkt_fifo #(.WIDTH(PACKET_SIZE), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (last_flit),
        .push_data  (assembled),
        .ready      (pkt_ready),
        .head_data  (pkt_data),
        .head_valid (pkt_valid),
        .next_count (next_count),
        .dropped    (dropped)
    );

    // One slot stays free for the packet the router may already have in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            neuron_full  <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            neuron_full <= (next_count >= CNTW'(FIFO_DEPTH - 1));
            if (dropped) overflow_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_local_flit_receiver.sv
// Scoreboard bench: a flit-level reference model queues expected packets, a monitor checks deliveries.
module tb_local_flit_receiver;
    localparam int DEPTH = 4;
`ifdef RX_TIMEOUT_EN
    localparam int TO = 16;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  flit_in = '0;
    logic        write_req = 1'b0;
    logic        neuron_full;
    logic [31:0] pkt_data;
    logic        pkt_valid;
    logic        pkt_ready = 1'b0;
    logic        overflow_err;
    logic        timeout_err;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];
    logic [3:0]  partial[$];
    int          occ = 0;
    bit          exp_ovf = 1'b0;
    bit          exp_to = 1'b0;
    int          idle = 0;

    always #5 clk = ~clk;

    local_flit_receiver #(
        .FIFO_DEPTH(DEPTH)
`ifdef RX_TIMEOUT_EN
        , .TIMEOUT_CYCLES(TO)
`endif
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flit_in      (flit_in),
        .write_req    (write_req),
        .neuron_full  (neuron_full),
        .pkt_data     (pkt_data),
        .pkt_valid    (pkt_valid),
        .pkt_ready    (pkt_ready),
        .overflow_err (overflow_err),
        .timeout_err  (timeout_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: flits gathered per packet, FIFO tracked as a plain occupancy number.
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            partial.delete();
            occ = 0; exp_ovf = 0; exp_to = 0; idle = 0;
        end else begin
            logic        pop;
            logic [31:0] pkt;
            check("neuron_full", neuron_full, (occ >= DEPTH - 1));
            check("overflow_err", overflow_err, exp_ovf);
            check("timeout_err", timeout_err, exp_to);
            pop = pkt_valid && pkt_ready;
            if (write_req) begin
                idle = 0;
                partial.push_back(flit_in);
                if (partial.size() == 8) begin
                    pkt = '0;
                    for (int i = 0; i < 8; i++) pkt[i*4 +: 4] = partial[i];
                    partial.delete();
                    if (occ < DEPTH || pop) begin
                        exp_q.push_back(pkt);
                        occ++;
                    end else begin
                        exp_ovf = 1'b1;
                    end
                end
            end else if (partial.size() > 0) begin
`ifdef RX_TIMEOUT_EN
                idle++;
                if (idle == TO) begin
                    partial.delete();
                    idle = 0;
                    exp_to = 1'b1;
                end
`endif
            end
            if (pop) occ--;
        end
    end

    // Output monitor: every delivered packet must match the oldest expected one.
    always @(negedge clk) begin
        if (reset && pkt_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pkt", pkt_data, 32'hxxxx_xxxx);
            end else if (pkt_ready) begin
                check("pkt_data", pkt_data, exp_q.pop_front());
            end else begin
                check("pkt_hold", pkt_data, exp_q[0]);
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; write_req = 1'b0; pkt_ready = 1'b0;
        cycle(); cycle();
        reset = 1'b1;
        check("rst_pkt_valid", pkt_valid, 1'b0);
        check("rst_pkt_data", pkt_data, 32'h0);
        check("rst_neuron_full", neuron_full, 1'b0);
        check("rst_overflow", overflow_err, 1'b0);
        check("rst_timeout", timeout_err, 1'b0);
    endtask

    task automatic send_flit(input logic [3:0] f);
        write_req = 1'b1; flit_in = f;
        cycle();
        write_req = 1'b0;
    endtask

    task automatic send_pkt(input logic [31:0] p, input int gap_after, input int gap_len);
        logic [31:0] v;
        v = p;
        for (int i = 0; i < 8; i++) begin
            send_flit(v[i*4 +: 4]);
            if (i == gap_after) repeat (gap_len) cycle();
        end
    endtask

    task automatic drain();
        int n;
        pkt_ready = 1'b1; write_req = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            cycle();
            n++;
        end
        cycle();
        check("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        do_reset();

        // Single packet, latency and one-cycle valid pulse.
        pkt_ready = 1'b1;
        send_pkt(32'h8765_4321, -1, 0);
        check("lat_n", pkt_valid, 1'b0);
        cycle();
        check("lat_n1_valid", pkt_valid, 1'b1);
        check("lat_n1_data", pkt_data, 32'h8765_4321);
        cycle();
        check("lat_n2_valid", pkt_valid, 1'b0);

        // Gaps between flits 4 and 5.
        send_pkt(32'h8765_4321, 3, 3);
        drain();

        // Backpressure and overflow.
        pkt_ready = 1'b0;
        send_pkt(32'h1111_1111, -1, 0);
        send_pkt(32'h2222_2222, -1, 0);
        send_pkt(32'h3333_3333, -1, 0);
        cycle();
        check("bp_full_after3", neuron_full, 1'b1);
        send_pkt(32'h4444_4444, -1, 0);
        send_pkt(32'h5555_5555, -1, 0);
        cycle();
        check("bp_overflow", overflow_err, 1'b1);
        drain();

        // Simultaneous push and pop at count 3.
        do_reset();
        send_pkt(32'hA000_0001, -1, 0);
        send_pkt(32'hA000_0002, -1, 0);
        send_pkt(32'hA000_0003, -1, 0);
        cycle(); cycle();
        for (int i = 0; i < 7; i++) send_flit(4'h4 + 4'(i));
        pkt_ready = 1'b1;
        send_flit(4'hB);
        pkt_ready = 1'b0;
        check("pp_full", neuron_full, 1'b1);
        drain();

        // Reset mid-packet.
        for (int i = 0; i < 5; i++) send_flit(4'(i + 1));
        do_reset();
        pkt_ready = 1'b1;
        send_pkt(32'hA5A5_A5A5, -1, 0);
        drain();

        // Idle timeout behaviour.
        do_reset();
        pkt_ready = 1'b1;
        send_flit(4'h1); send_flit(4'h2); send_flit(4'h3);
        repeat (16) cycle();
        send_pkt(32'h89AB_CDEF, -1, 0);
`ifdef RX_TIMEOUT_EN
        check("to_err_set", timeout_err, 1'b1);
`else
        check("to_err_clear", timeout_err, 1'b0);
`endif
        drain();

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            write_req = ($urandom_range(0, 9) < 7) && (!neuron_full || $urandom_range(0, 7) == 0);
            flit_in   = 4'($urandom_range(0, 15));
            pkt_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
